// File: rtl/dmi_req_shaper.sv
`default_nettype none
// ============================================================================
// Module   : dmi_req_shaper
// Brief    : DMI request FIFO with outstanding limit, post-write idle gap and
//            synthetic error responses on response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module dmi_req_shaper #(
    parameter int ADDR_W          = 7,
    parameter int DATA_W          = 32,
    parameter int REQ_DEPTH       = 4,
    parameter int WRITE_DELAY     = 200,
    parameter int MAX_OUTSTANDING = 2,
    parameter int RESP_TIMEOUT    = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              h_req_valid,
    output logic              h_req_ready,
    input  logic [ADDR_W-1:0] h_req_addr,
    input  logic [1:0]        h_req_op,
    input  logic [DATA_W-1:0] h_req_data,
    output logic              h_resp_valid,
    input  logic              h_resp_ready,
    output logic [1:0]        h_resp_resp,
    output logic [DATA_W-1:0] h_resp_data,
    output logic              dmi_req_valid,
    input  logic              dmi_req_ready,
    output logic [ADDR_W-1:0] dmi_req_bits_addr,
    output logic [1:0]        dmi_req_bits_op,
    output logic [DATA_W-1:0] dmi_req_bits_data,
    input  logic              dmi_resp_valid,
    output logic              dmi_resp_ready,
    input  logic [1:0]        dmi_resp_bits_resp,
    input  logic [DATA_W-1:0] dmi_resp_bits_data,
    output logic              timeout_pulse,
    output logic              busy
);

    localparam int c_PTR_W = $clog2(REQ_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_GAP_W = (WRITE_DELAY > 1) ? $clog2(WRITE_DELAY + 1) : 1;
    localparam int c_TMR_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;
    localparam int c_ENT_W = ADDR_W + 2 + DATA_W;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(REQ_DEPTH);
    localparam logic [c_OUT_W-1:0] c_OUT_ONE   = c_OUT_W'(1);
    localparam logic [c_OUT_W-1:0] c_MAX_OUT   = c_OUT_W'(MAX_OUTSTANDING);
    localparam logic [c_GAP_W-1:0] c_GAP_ONE   = c_GAP_W'(1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD  = c_GAP_W'(WRITE_DELAY);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
    localparam logic [c_TMR_W-1:0] c_TMR_LIMIT = c_TMR_W'(RESP_TIMEOUT);
    localparam bit                 c_GAP_EN    = (WRITE_DELAY > 0);
    localparam bit                 c_TMO_EN    = (RESP_TIMEOUT > 0);

    localparam logic [0:0] c_S_ISSUE = 1'b0;
    localparam logic [0:0] c_S_GAP   = 1'b1;

    logic [c_ENT_W-1:0] r_mem [REQ_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [0:0]         r_state;
    logic [c_GAP_W-1:0] r_gap;
    logic [c_OUT_W-1:0] r_out;
    logic [c_OUT_W-1:0] r_stale;
    logic [c_TMR_W-1:0] r_timer;
    logic               r_resp_full;
    logic [1:0]         r_resp_code;
    logic [DATA_W-1:0]  r_resp_data;
    logic               r_timeout_pulse;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [c_ENT_W-1:0] w_head;
    logic               w_head_is_write;
    logic               w_resp_acc;
    logic               w_stale_nz;
    logic               w_load_real;
    logic               w_drop;
    logic               w_tmo_fire;
    logic               w_out_dec;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_head  = r_mem[r_rd_ptr];

    // Handshake outputs are held low while reset is asserted.
    assign h_req_ready    = !reset && !w_full;
    assign dmi_req_valid  = !reset && (r_state == c_S_ISSUE) && !w_empty && (r_out < c_MAX_OUT);
    assign dmi_resp_ready = !reset && (!r_resp_full || h_resp_ready);

    assign w_push          = h_req_valid && h_req_ready;
    assign w_pop           = dmi_req_valid && dmi_req_ready;
    assign w_head_is_write = (w_head[DATA_W +: 2] == 2'd2);

    assign dmi_req_bits_addr = w_head[c_ENT_W-1 -: ADDR_W];
    assign dmi_req_bits_op   = w_head[DATA_W +: 2];
    assign dmi_req_bits_data = w_head[DATA_W-1:0];

    assign w_resp_acc  = dmi_resp_valid && dmi_resp_ready;
    assign w_stale_nz  = (r_stale != '0);
    assign w_load_real = w_resp_acc && !w_stale_nz;
    assign w_drop      = w_resp_acc && w_stale_nz;

    // A real response in the expiry cycle takes priority over the synthetic one.
    assign w_tmo_fire = c_TMO_EN && (r_timer == c_TMR_LIMIT) && (r_out != '0)
                        && !w_resp_acc && (!r_resp_full || h_resp_ready);
    assign w_out_dec  = (w_load_real && (r_out != '0)) || w_tmo_fire;

    assign h_resp_valid  = r_resp_full;
    assign h_resp_resp   = r_resp_code;
    assign h_resp_data   = r_resp_data;
    assign timeout_pulse = r_timeout_pulse;
    assign busy          = !w_empty || (r_out != '0) || (r_state == c_S_GAP) || r_resp_full;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REQ_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {h_req_addr, h_req_op, h_req_data};
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_S_ISSUE;
            r_gap   <= '0;
        end else begin
            case (r_state)
                c_S_ISSUE: begin
                    if (w_pop && w_head_is_write && c_GAP_EN) begin
                        r_gap   <= c_GAP_LOAD;
                        r_state <= c_S_GAP;
                    end
                end
                default: begin
                    r_gap <= r_gap - c_GAP_ONE;
                    if (r_gap == c_GAP_ONE) begin
                        r_state <= c_S_ISSUE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_out   <= '0;
            r_stale <= '0;
            r_timer <= '0;
        end else begin
            case ({w_pop, w_out_dec})
                2'b10:   r_out <= r_out + c_OUT_ONE;
                2'b01:   r_out <= r_out - c_OUT_ONE;
                default: r_out <= r_out;
            endcase
            // Each timed-out request may still answer later; that answer is discarded.
            if (w_tmo_fire && (r_stale != c_MAX_OUT)) begin
                r_stale <= r_stale + c_OUT_ONE;
            end else if (w_drop) begin
                r_stale <= r_stale - c_OUT_ONE;
            end
            if (!c_TMO_EN || (r_out == '0) || w_resp_acc || w_tmo_fire) begin
                r_timer <= '0;
            end else if (r_timer != c_TMR_LIMIT) begin
                r_timer <= r_timer + c_TMR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_resp_full     <= 1'b0;
            r_resp_code     <= 2'd0;
            r_resp_data     <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_tmo_fire;
            if (w_load_real) begin
                r_resp_full <= 1'b1;
                r_resp_code <= dmi_resp_bits_resp;
                r_resp_data <= dmi_resp_bits_data;
            end else if (w_tmo_fire) begin
                r_resp_full <= 1'b1;
                r_resp_code <= 2'd2;
                r_resp_data <= '0;
            end else if (r_resp_full && h_resp_ready) begin
                r_resp_full <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
